// File: rtl/regfile_pkg.sv
// Shared types and defaults for the integer register file and its busy scoreboard.
// Optional feature macro (defined in the top): REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int XLEN_DEF  = 64;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef logic [AW_DEF-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Busy scoreboard: one busy bit per register, WAW issue check, flush and a
// registered count of busy registers. Bit 0 (x0) is never set.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NREGS = NREGS_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] rs1Addr,
   input  logic [AW-1:0] rs2Addr,
   output logic          rs1Busy,
   output logic          rs2Busy,
   input  logic          issueValid,
   input  logic [AW-1:0] issueRd,
   output logic          issueOk,
   input  logic          wbValid,
   input  logic [AW-1:0] wbRd,
   input  logic          flush,
   output logic [AW:0]   busyCnt
);

   logic [NREGS-1:0] busyQ;
   logic [NREGS-1:0] busyNext;
   logic [AW:0]      cntNext;

   // A busy destination may be reissued only if its producer retires on this same edge.
   assign issueOk = issueValid &&
                    (issueRd == '0 || !busyQ[issueRd] || (wbValid && wbRd == issueRd));

   assign rs1Busy = busyQ[rs1Addr];
   assign rs2Busy = busyQ[rs2Addr];

   // Next busy state: wb clears, a new producer sets afterwards (so it wins), flush clears all.
   always_comb begin
      busyNext = busyQ;
      if (wbValid && wbRd != '0) busyNext[wbRd] = 1'b0;
      if (issueOk && issueRd != '0) busyNext[issueRd] = 1'b1;
      if (flush) busyNext = '0;
      busyNext[0] = 1'b0;
   end

   // Popcount of the next state so busyCnt tracks busyQ exactly after the edge.
   always_comb begin
      cntNext = '0;
      for (int i = 1; i < NREGS; i++) cntNext = cntNext + (AW+1)'(busyNext[i]);
   end

   // Scoreboard state and count registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busyQ   <= '0;
         busyCnt <= '0;
      end else begin
         busyQ   <= busyNext;
         busyCnt <= cntNext;
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// 2R/1W integer register file with per-register busy scoreboard.
// x0 reads as zero and is always ready.
// Optional macro REGFILE_BYPASS_EN: forward same-cycle writeback data to reads.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEF,
   parameter  int NREGS = NREGS_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_ready,
   output logic            rs2_ready,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_ok,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic [AW:0]     busy_cnt
);

   logic [XLEN-1:0] regs [NREGS];
   logic            rs1Busy, rs2Busy;
   logic            fwd1, fwd2;

   reg_scoreboard #(.NREGS(NREGS)) uSb (
      .clk        (clk),
      .rst        (rst),
      .rs1Addr    (rs1_addr),
      .rs2Addr    (rs2_addr),
      .rs1Busy    (rs1Busy),
      .rs2Busy    (rs2Busy),
      .issueValid (issue_valid),
      .issueRd    (issue_rd),
      .issueOk    (issue_ok),
      .wbValid    (wb_valid),
      .wbRd       (wb_rd),
      .flush      (flush),
      .busyCnt    (busy_cnt)
   );

   // Data array; writes to x0 are dropped, a flush does not cancel a writeback.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_valid && wb_rd != '0) begin
         regs[wb_rd] <= wb_data;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Gated by rst so that reads stay zero while reset is held.
   assign fwd1 = rst && wb_valid && wb_rd == rs1_addr && rs1_addr != '0;
   assign fwd2 = rst && wb_valid && wb_rd == rs2_addr && rs2_addr != '0;
`else
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif

   assign rs1_data  = fwd1 ? wb_data : ((rs1_addr == '0) ? '0 : regs[rs1_addr]);
   assign rs2_data  = fwd2 ? wb_data : ((rs2_addr == '0) ? '0 : regs[rs2_addr]);
   assign rs1_ready = (rs1_addr == '0) || !rs1Busy || fwd1;
   assign rs2_ready = (rs2_addr == '0) || !rs2Busy || fwd2;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus pushes expected values,
// a negedge monitor pops and compares against the live outputs.
module tb_regfile_scoreboard;

   localparam int XLEN  = 64;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   localparam int S_D1 = 0, S_D2 = 1, S_R1 = 2, S_R2 = 3, S_OK = 4, S_CNT = 5;

   typedef struct {
      string       name;
      int          sel;
      logic [63:0] exp;
   } chk_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   rs1Addr, rs2Addr, issueRd, wbRd;
   logic [XLEN-1:0] rs1Data, rs2Data, wbData;
   logic            rs1Ready, rs2Ready, issueValid, issueOk, wbValid, flush;
   logic [AW:0]     busyCnt;

   chk_t expQ[$];
   chk_t item;
   logic [63:0] act;
   int passed = 0;
   int total  = 0;

   regfile_scoreboard dut (
      .clk         (clk),
      .rst         (rst),
      .rs1_addr    (rs1Addr),
      .rs2_addr    (rs2Addr),
      .rs1_data    (rs1Data),
      .rs2_data    (rs2Data),
      .rs1_ready   (rs1Ready),
      .rs2_ready   (rs2Ready),
      .issue_valid (issueValid),
      .issue_rd    (issueRd),
      .issue_ok    (issueOk),
      .wb_valid    (wbValid),
      .wb_rd       (wbRd),
      .wb_data     (wbData),
      .flush       (flush),
      .busy_cnt    (busyCnt)
   );

   always #5 clk = ~clk;

   task automatic want(input string n, input int sel, input logic [63:0] v);
      chk_t c;
      c.name = n;
      c.sel  = sel;
      c.exp  = v;
      expQ.push_back(c);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issueValid = 1'b0;
      wbValid    = 1'b0;
      flush      = 1'b0;
   endtask

   // Monitor: compare all pending expectations against the outputs at the falling edge.
   always @(negedge clk) begin
      while (expQ.size() > 0) begin
         item = expQ.pop_front();
         case (item.sel)
            S_D1:    act = rs1Data;
            S_D2:    act = rs2Data;
            S_R1:    act = {63'd0, rs1Ready};
            S_R2:    act = {63'd0, rs2Ready};
            S_OK:    act = {63'd0, issueOk};
            default: act = {58'd0, busyCnt};
         endcase
         total++;
         if (act === item.exp) passed++;
         else $display("FAIL %s: got %0h expected %0h", item.name, act, item.exp);
      end
   end

   initial begin
      rst = 1'b0;
      rs1Addr = '0; rs2Addr = '0; issueRd = '0; wbRd = '0; wbData = '0;
      idle();
      #1;
      // 1: reset state
      rs1Addr = 5'd7; rs2Addr = 5'd31;
      want("rst_d1", S_D1, 0); want("rst_r1", S_R1, 1);
      want("rst_d2", S_D2, 0); want("rst_r2", S_R2, 1); want("rst_cnt", S_CNT, 0);
      step(); step();
      rst = 1'b1;
      for (int a = 1; a < NREGS; a++) begin
         rs1Addr = AW'(a); rs2Addr = AW'(NREGS - a);
         want("init_d1", S_D1, 0); want("init_r1", S_R1, 1);
         want("init_r2", S_R2, 1);
         step();
      end
      want("init_cnt", S_CNT, 0);

      // 2: plain writes and x0 write ignored
      wbValid = 1'b1; wbRd = 5'd1; wbData = 64'd42;
      step();
      wbRd = 5'd2; wbData = -64'sd15;
      step();
      idle(); rs1Addr = 5'd1; rs2Addr = 5'd2;
      want("wr_x1", S_D1, 64'd42); want("wr_x2", S_D2, 64'hFFFF_FFFF_FFFF_FFF1);
      step();
      wbValid = 1'b1; wbRd = 5'd0; wbData = 64'd100; rs1Addr = 5'd0;
      step();
      idle();
      want("x0_data", S_D1, 0); want("x0_ready", S_R1, 1);
      step();

      // 3: issue, WAW stall, writeback release
      issueValid = 1'b1; issueRd = 5'd5; rs1Addr = 5'd5;
      want("iss5_ok", S_OK, 1); want("iss5_pre_ready", S_R1, 1);
      step();
      want("iss5_ready", S_R1, 0); want("iss5_cnt", S_CNT, 1);
      want("waw_ok", S_OK, 0);
      step();
      issueValid = 1'b0; wbValid = 1'b1; wbRd = 5'd5; wbData = 64'd7;
`ifdef REGFILE_BYPASS_EN
      want("wb5_same_ready", S_R1, 1); want("wb5_same_data", S_D1, 64'd7);
`else
      want("wb5_same_ready", S_R1, 0); want("wb5_same_data", S_D1, 64'd0);
`endif
      want("wb5_same_cnt", S_CNT, 1);
      step();
      idle();
      want("wb5_ready", S_R1, 1); want("wb5_data", S_D1, 64'd7); want("wb5_cnt", S_CNT, 0);
      step();

      // 4: same-edge issue and wb to rd 3; new producer keeps busy
      issueValid = 1'b1; issueRd = 5'd3; wbValid = 1'b1; wbRd = 5'd3; wbData = 64'd9;
      rs1Addr = 5'd3;
      want("iw3_ok", S_OK, 1);
      step();
      idle();
      want("iw3_data", S_D1, 64'd9); want("iw3_ready", S_R1, 0); want("iw3_cnt", S_CNT, 1);
      step();
      issueValid = 1'b1; issueRd = 5'd3; wbValid = 1'b1; wbRd = 5'd3; wbData = 64'd11;
      want("reiss3_ok", S_OK, 1);
      step();
      idle();
      want("reiss3_data", S_D1, 64'd11); want("reiss3_ready", S_R1, 0);
      want("reiss3_cnt", S_CNT, 1);
      wbValid = 1'b1; wbRd = 5'd3; wbData = 64'd9;
      step();
      idle();
      want("clr3_cnt", S_CNT, 0);
      step();

      // 5: several busy, then flush with issue 8 and wb 6
      issueValid = 1'b1; issueRd = 5'd4;
      step();
      issueRd = 5'd6;
      step();
      issueRd = 5'd7;
      step();
      issueRd = 5'd8; flush = 1'b1; wbValid = 1'b1; wbRd = 5'd6; wbData = 64'd66;
      rs1Addr = 5'd7;
      want("pre_flush_cnt", S_CNT, 3); want("pre_flush_r7", S_R1, 0);
      want("flush_iss_ok", S_OK, 1);
      step();
      idle(); rs1Addr = 5'd8; rs2Addr = 5'd6;
      want("flush_r8", S_R1, 1); want("flush_r6", S_R2, 1);
      want("flush_wb6", S_D2, 64'd66); want("flush_cnt", S_CNT, 0);
      step();
      rs1Addr = 5'd4; rs2Addr = 5'd7;
      want("flush_r4", S_R1, 1); want("flush_r7", S_R2, 1);
      step();

      // 6: async reset mid-operation
      issueValid = 1'b1; issueRd = 5'd10; wbValid = 1'b1; wbRd = 5'd11; wbData = 64'd123;
      step();
      idle(); rs1Addr = 5'd10; rs2Addr = 5'd11;
      want("pre_rst_r10", S_R1, 0); want("pre_rst_d11", S_D2, 64'd123);
      want("pre_rst_cnt", S_CNT, 1);
      step();
      #2;
      rst = 1'b0;
      want("arst_r10", S_R1, 1); want("arst_d11", S_D2, 0); want("arst_cnt", S_CNT, 0);
      step();
      rst = 1'b1;
      step();

      for (int i = 0; i < 10 && expQ.size() > 0; i++) step();
      if (expQ.size() > 0) begin
         total++;
         $display("FAIL drain: got %0d pending expected 0", expQ.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
